hs_unbs: RTL
============

# hs_unbs

High-speed receive-side bit unstuffer and deserializer for the UTMI block. It mirrors the transmit-side bit stuffer. It accepts one NRZI-decoded serial bit per clock and drops the stuffed zero inserted after every run of six ones. It assembles the remaining data bits LSB-first into bytes and presents each byte on a valid/ready holding register toward the receive-side link logic. It also flags bit-stuff errors (a run of seven ones) and holding-register overruns.

## Interface

Parameters:
- STUFF_LEN, 6, count of consecutive ones after which one stuffed zero is expected.

Ports:
- clk  input  1  bit clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- dataIn  input  1  NRZI-decoded serial bit, sampled when RX_EN=1.
- RX_EN  input  1  high for the duration of a received packet; low = bus idle/EOP.
- RX_READY  input  1  consumer accepts the holding byte this cycle.
- dataOut  output  8  holding-register byte, LSB = first received data bit.
- RX_VALID  output  1  holding register full; held until accepted.
- RX_ACTIVE  output  1  packet reception in progress.
- RX_ERROR  output  1  sticky bit-stuff error flag for the current packet.
- RX_OVERRUN  output  1  sticky flag: a completed byte was dropped because the holding register was full.

## Operation

- Reset (rst=1 at an edge): all outputs are 0, including dataOut=8'h00. State=IDLE, bit index=0, ones count=0, shift register=0. rst overrides everything else, including mid-byte and mid-packet.
- State IDLE:
  - When RX_EN=1 at an edge: clear RX_ERROR and RX_OVERRUN, then process dataIn as the packet's first bit (rules below).
  - Next state=ACTIVE and RX_ACTIVE=1.
- State ACTIVE, each edge with RX_EN=1:
  - If ones count==STUFF_LEN and dataIn=0: this is a stuffed bit. Discard it, set ones count=0, bit index unchanged.
  - If ones count==STUFF_LEN and dataIn=1: this is a stuff error.
    - Set RX_ERROR=1 and discard the partial byte.
    - Next state=ERROR.
    - No byte is produced for this cycle.
  - Otherwise this is a data bit:
    - Write shift[index]=dataIn.
    - Ones count = dataIn ? count+1 : 0.
    - Index increments modulo 8.
  - The ones count carries across byte boundaries. It is never cleared at index wrap.
- Byte completion (data bit accepted with index==7): the byte is {dataIn, shift[6:0]}.
  - If RX_VALID=0, or RX_VALID=1 and RX_READY=1 in the same cycle: load dataOut and set RX_VALID=1.
  - Otherwise: drop the new byte, keep dataOut unchanged, set RX_OVERRUN=1.
- Handshake: when RX_VALID=1 and RX_READY=1 at an edge with no simultaneous completion, RX_VALID becomes 0. A byte already in the holding register survives end of packet and the ERROR state until accepted.
- State ERROR: dataIn is ignored. RX_ACTIVE stays 1 and RX_ERROR stays 1.
- RX_EN=0 at an edge in ACTIVE or ERROR:
  - Any partial byte (index≠0) is discarded silently. No error is flagged for this.
  - Set index=0, ones count=0, RX_ACTIVE=0, next state=IDLE.
  - RX_ERROR and RX_OVERRUN keep their values until the next packet start or rst.
- RX_EN=0 in IDLE: no state change.

## Timing

- All outputs are registered. Each changes only at the posedge that follows the qualifying input sample.
- Byte latency: RX_VALID rises and dataOut updates at the same edge that samples the byte's last data bit.
- Stuff error: RX_ERROR rises at the edge that samples the seventh consecutive one.
- RX_ACTIVE rises at the edge that samples the first RX_EN=1. It falls at the edge that samples the first RX_EN=0.
- Throughput: at most one byte per 8 data-bit cycles. The consumer must assert RX_READY within 8 cycles of RX_VALID, otherwise an overrun occurs.
- Simultaneous events: accept and completion at the same edge leaves RX_VALID=1 with the new byte. rst beats RX_EN and RX_READY.

## Test plan

- Byte 0xA5 sent LSB-first as 1,0,1,0,0,1,0,1 with RX_EN=1 and RX_READY=1 → RX_VALID=1 for exactly one cycle after the 8th bit, dataOut=8'hA5, RX_ERROR=0.
- Two bytes 0xFF sent as 111111 0 11 1111 0 1111 (18 cycles) → two RX_VALID pulses, each with dataOut=8'hFF. Both stuffed zeros are dropped and RX_ERROR=0. This checks that the ones count carries across the byte boundary.
- Seven ones after RX_EN rises → RX_ERROR=1 at the 7th one, no RX_VALID, RX_ACTIVE held 1. Then drop RX_EN and start a new packet with 0x00 → RX_ERROR clears at packet start and dataOut=8'h00.
- RX_READY=0 throughout while bytes 0x12 then 0x34 are sent → RX_VALID=1 with dataOut=8'h12, RX_OVERRUN=1 at the 16th bit. Then raise RX_READY → RX_VALID=0 on the next edge.
- RX_EN dropped after 3 data bits → no RX_VALID, and RX_ACTIVE=0 one edge after RX_EN falls. The next packet with 0x5A yields dataOut=8'h5A.
- rst asserted mid-byte, and separately with RX_VALID=1 pending → all outputs 0 on the next edge. The following packet 0x3C decodes correctly to dataOut=8'h3C.

Source files
------------

// File: rtl/hs_unbs.sv
// hs_unbs: high-speed receive bit unstuffer and deserializer.
// Drops the stuffed zero after each run of STUFF_LEN ones and packs
// the remaining data bits LSB-first into bytes on a valid/ready
// holding register. Flags stuff errors and holding-register overruns.
//
// Ports:
//   clk        bit clock, posedge
//   rst        synchronous active-high reset
//   dataIn     NRZI-decoded serial bit, sampled while RX_EN=1
//   RX_EN      high during a received packet
//   RX_READY   consumer accepts the holding byte this cycle
//   dataOut    holding-register byte
//   RX_VALID   holding register full, held until accepted
//   RX_ACTIVE  packet reception in progress
//   RX_ERROR   sticky bit-stuff error for the current packet
//   RX_OVERRUN sticky flag: a completed byte was dropped
module hs_unbs #(
    parameter int STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dataIn,
    input  logic       RX_EN,
    input  logic       RX_READY,
    output logic [7:0] dataOut,
    output logic       RX_VALID,
    output logic       RX_ACTIVE,
    output logic       RX_ERROR,
    output logic       RX_OVERRUN
);

    localparam int CW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_ones;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_active;
    logic            r_error;
    logic            r_overrun;

    logic            w_run;
    logic            w_full;
    logic            w_stuff;
    logic            w_serr;
    logic            w_data;
    logic            w_done;
    logic            w_accept;
    logic            w_load;
    logic [7:0]      w_byte;

    // In IDLE the counters are already zero, so the first bit of a
    // packet always takes the data-bit path.
    always_comb begin
        w_run    = RX_EN && (r_state != S_ERROR);
        w_full   = (r_ones == CW'(STUFF_LEN));
        w_stuff  = w_run && w_full && !dataIn;
        w_serr   = w_run && w_full && dataIn;
        w_data   = w_run && !w_full;
        w_done   = w_data && (r_idx == 3'd7);
        w_accept = r_valid && RX_READY;
        w_load   = w_done && (!r_valid || RX_READY);
        w_byte   = {dataIn, r_shift[6:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_ones    <= '0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Holding register: a completion in the same cycle as an
            // accept wins, leaving the new byte valid.
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_load) begin
                r_data  <= w_byte;
                r_valid <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (RX_EN) begin
                        r_state   <= S_ACTIVE;
                        r_active  <= 1'b1;
                        r_error   <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end
                S_ACTIVE, S_ERROR: begin
                    if (!RX_EN) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                        r_idx    <= 3'd0;
                        r_ones   <= '0;
                    end else if (w_serr) begin
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                        r_idx   <= 3'd0;
                        r_ones  <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_stuff) begin
                r_ones <= '0;
            end

            // Ones count carries across byte boundaries.
            if (w_data) begin
                r_shift[r_idx] <= dataIn;
                r_ones         <= dataIn ? r_ones + CW'(1) : '0;
                r_idx          <= r_idx + 3'd1;
            end

            if (w_done && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dataOut    = r_data;
    assign RX_VALID   = r_valid;
    assign RX_ACTIVE  = r_active;
    assign RX_ERROR   = r_error;
    assign RX_OVERRUN = r_overrun;

endmodule
